// File: rtl/data_mem_arbiter.sv
// Two-requester front end for a single-read/single-write-port data memory.
// Read and write ports are round-robin arbitrated independently; read data returns one cycle after grant.
module data_mem_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  rd0_valid,
  output logic [DATA_WIDTH-1:0] rd0_data,
  output logic                  rd1_valid,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic [ADDR_WIDTH-1:0] mem_addr_r,
  output logic [ADDR_WIDTH-1:0] mem_addr_w,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  logic rd_ptr_q, rd_ptr_d;
  logic wr_ptr_q, wr_ptr_d;
  logic rvalid_q, rvalid_d;
  logic owner_q, owner_d;

  logic rreq0, rreq1, wreq0, wreq1;
  logic rgnt, wgnt, rwin, wwin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= 1'b1;
      wr_ptr_q <= 1'b1;
      rvalid_q <= 1'b0;
      owner_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rvalid_q <= rvalid_d;
      owner_q  <= owner_d;
    end
  end

  // Pointer names the last winner, so on contention the other index wins.
  always_comb begin
    rreq0 = ~reset & req0_valid & ~req0_we;
    rreq1 = ~reset & req1_valid & ~req1_we;
    wreq0 = ~reset & req0_valid & req0_we;
    wreq1 = ~reset & req1_valid & req1_we;
    rgnt  = rreq0 | rreq1;
    wgnt  = wreq0 | wreq1;
    rwin  = (rreq0 & rreq1) ? ~rd_ptr_q : rreq1;
    wwin  = (wreq0 & wreq1) ? ~wr_ptr_q : wreq1;
    rd_ptr_d = rgnt ? rwin : rd_ptr_q;
    wr_ptr_d = wgnt ? wwin : wr_ptr_q;
    rvalid_d = rgnt;
    owner_d  = rgnt ? rwin : owner_q;
  end

  always_comb begin
    req0_ready  = (rgnt & ~rwin) | (wgnt & ~wwin);
    req1_ready  = (rgnt & rwin) | (wgnt & wwin);
    mem_addr_r  = rwin ? req1_addr : req0_addr;
    mem_we      = wgnt;
    mem_addr_w  = wwin ? req1_addr : req0_addr;
    mem_data_in = wwin ? req1_wdata : req0_wdata;
    rd0_valid   = ~reset & rvalid_q & ~owner_q;
    rd1_valid   = ~reset & rvalid_q & owner_q;
    rd0_data    = mem_data_out;
    rd1_data    = mem_data_out;
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural registered-read memory attached.
module tb_data_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_we, req0_ready;
  logic [7:0]  req0_addr;
  logic [15:0] req0_wdata;
  logic        req1_valid, req1_we, req1_ready;
  logic [7:0]  req1_addr;
  logic [15:0] req1_wdata;
  logic        rd0_valid, rd1_valid;
  logic [15:0] rd0_data, rd1_data;
  logic [7:0]  mem_addr_r, mem_addr_w;
  logic [15:0] mem_data_in, mem_data_out;
  logic        mem_we;

  logic [15:0] mem [256];

  int vectors;
  int miscompares;

  data_mem_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rd0_valid(rd0_valid), .rd0_data(rd0_data),
    .rd1_valid(rd1_valid), .rd1_data(rd1_data),
    .mem_addr_r(mem_addr_r), .mem_addr_w(mem_addr_w),
    .mem_data_in(mem_data_in), .mem_we(mem_we), .mem_data_out(mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered read returns the pre-write value when read and write hit the same word.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr_w] <= mem_data_in;
    mem_data_out <= mem[mem_addr_r];
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h01; req0_wdata = 16'h1234;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h02; req1_wdata = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if (req0_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req0_ready got %b want 0", req0_ready); end
      vectors++;
      if (req1_ready !== 1'b0) begin miscompares++; $display("FAIL reset_req1_ready got %b want 0", req1_ready); end
      vectors++;
      if (mem_we !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      vectors++;
      if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin
        miscompares++; $display("FAIL reset_rd_valid got %b%b want 00", rd0_valid, rd1_valid);
      end
    end
    idle();
    reset = 1'b0;
  endtask

  task automatic test_alternating_read;
    logic [7:0]  pa [3];
    logic [15:0] pd [3];
    logic        w;
    pa[0] = 8'h10; pa[1] = 8'h20; pa[2] = 8'h05;
    pd[0] = 16'h1111; pd[1] = 16'h2222; pd[2] = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = pa[i]; req0_wdata = pd[i];
      #3;
      vectors++;
      if (req0_ready !== 1'b1 || mem_we !== 1'b1) begin
        miscompares++; $display("FAIL preload_write ready=%b we=%b want 1 1", req0_ready, mem_we);
      end
      step();
    end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
    for (int k = 0; k < 4; k++) begin
      w = k[0];
      #3;
      vectors++;
      if (req0_ready !== ~w || req1_ready !== w) begin
        miscompares++; $display("FAIL alt_grant cycle %0d got %b%b want %b%b", k, req0_ready, req1_ready, ~w, w);
      end
      vectors++;
      if (mem_addr_r !== (w ? 8'h20 : 8'h10)) begin
        miscompares++; $display("FAIL alt_addr_r cycle %0d got %h want %h", k, mem_addr_r, (w ? 8'h20 : 8'h10));
      end
      step();
      if (k == 3) idle();
      vectors++;
      if (rd0_valid !== ~w || rd1_valid !== w) begin
        miscompares++; $display("FAIL alt_rd_valid cycle %0d got %b%b want %b%b", k, rd0_valid, rd1_valid, ~w, w);
      end
      vectors++;
      if ((w ? rd1_data : rd0_data) !== (w ? 16'h2222 : 16'h1111)) begin
        miscompares++; $display("FAIL alt_rd_data cycle %0d got %h want %h", k, (w ? rd1_data : rd0_data), (w ? 16'h2222 : 16'h1111));
      end
    end
  endtask

  task automatic test_read_write_same_addr;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h05; req0_wdata = 16'hABCD;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h05;
    #3;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b1) begin
      miscompares++; $display("FAIL rw_both_ready got %b%b want 11", req0_ready, req1_ready);
    end
    vectors++;
    if (mem_we !== 1'b1 || mem_addr_w !== 8'h05 || mem_data_in !== 16'hABCD || mem_addr_r !== 8'h05) begin
      miscompares++; $display("FAIL rw_mem_port we=%b aw=%h din=%h ar=%h want 1 05 abcd 05", mem_we, mem_addr_w, mem_data_in, mem_addr_r);
    end
    step();
    req0_valid = 1'b0;
    vectors++;
    if (rd1_valid !== 1'b1 || rd0_valid !== 1'b0 || rd1_data !== 16'h0000) begin
      miscompares++; $display("FAIL rw_old_data v=%b%b data=%h want 01 0000", rd0_valid, rd1_valid, rd1_data);
    end
    #3;
    vectors++;
    if (req1_ready !== 1'b1) begin miscompares++; $display("FAIL rw_reread_ready got %b want 1", req1_ready); end
    step();
    idle();
    vectors++;
    if (rd1_valid !== 1'b1 || rd1_data !== 16'hABCD) begin
      miscompares++; $display("FAIL rw_new_data v=%b data=%h want 1 abcd", rd1_valid, rd1_data);
    end
  endtask

  task automatic test_single_writer;
    req1_valid = 1'b1; req1_we = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req1_addr = 8'h40 + 8'(k); req1_wdata = 16'h5000 + 16'(k);
      #3;
      vectors++;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
        miscompares++; $display("FAIL single_wr_ready cycle %0d got %b%b want 01", k, req0_ready, req1_ready);
      end
      vectors++;
      if (mem_we !== 1'b1 || mem_addr_w !== (8'h40 + 8'(k))) begin
        miscompares++; $display("FAIL single_wr_mem cycle %0d we=%b aw=%h want 1 %h", k, mem_we, mem_addr_w, 8'h40 + 8'(k));
      end
      step();
    end
    idle();
  endtask

  task automatic test_back_to_back_write;
    logic [1:0] exp [5];
    exp[0] = 2'b01; exp[1] = 2'b10; exp[2] = 2'b01; exp[3] = 2'b01; exp[4] = 2'b01;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'h60; req0_wdata = 16'hAAAA;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 8'h61; req1_wdata = 16'hBBBB;
    for (int k = 0; k < 5; k++) begin
      #3;
      vectors++;
      if ({req1_ready, req0_ready} !== exp[k]) begin
        miscompares++; $display("FAIL b2b_grant cycle %0d got %b want %b", k, {req1_ready, req0_ready}, exp[k]);
      end
      vectors++;
      if (mem_we !== 1'b1 || mem_data_in !== (exp[k][1] ? 16'hBBBB : 16'hAAAA)) begin
        miscompares++; $display("FAIL b2b_mem cycle %0d we=%b din=%h", k, mem_we, mem_data_in);
      end
      step();
      if (k == 1) req1_valid = 1'b0;
    end
    idle();
  endtask

  task automatic test_reset_mid_read;
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    #3;
    vectors++;
    if (req0_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_grant got %b want 1", req0_ready); end
    step();
    idle();
    vectors++;
    if (rd0_valid !== 1'b1) begin miscompares++; $display("FAIL midrst_pending got %b want 1", rd0_valid); end
    reset = 1'b1;
    #1;
    vectors++;
    if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin
      miscompares++; $display("FAIL midrst_immediate got %b%b want 00", rd0_valid, rd1_valid);
    end
    step();
    reset = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      vectors++;
      if (rd0_valid !== 1'b0 || rd1_valid !== 1'b0) begin
        miscompares++; $display("FAIL midrst_after cycle %0d got %b%b want 00", k, rd0_valid, rd1_valid);
      end
    end
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'h10;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'h20;
    #3;
    vectors++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      miscompares++; $display("FAIL midrst_first_prio got %b%b want 10", req0_ready, req1_ready);
    end
    step();
    idle();
    vectors++;
    if (rd0_valid !== 1'b1 || rd1_valid !== 1'b0 || rd0_data !== 16'h1111) begin
      miscompares++; $display("FAIL midrst_read v=%b%b data=%h want 10 1111", rd0_valid, rd1_valid, rd0_data);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = 8'h00; req0_wdata = 16'h0000;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 8'h00; req1_wdata = 16'h0000;
    test_reset();
    test_alternating_read();
    test_read_write_same_addr();
    test_single_writer();
    test_back_to_back_write();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 16, memory word width.
REQ-002 Parameters SHALL be: ADDR_WIDTH, default 8, memory word address width.
REQ-003 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 Ports reqN_valid  input  1  (N=0,1) SHALL mean requester N presents a transaction.
REQ-006 Ports reqN_we  input  1  SHALL select write (1) or read (0).
REQ-007 Ports reqN_addr  input  ADDR_WIDTH  SHALL carry the word address.
REQ-008 Ports reqN_wdata  input  DATA_WIDTH  SHALL carry the write data.
REQ-009 Ports reqN_ready  output  1  SHALL mean the transaction is accepted this cycle.
REQ-010 Ports rdN_valid  output  1  SHALL mark read data for requester N.
REQ-011 Ports rdN_data  output  DATA_WIDTH  SHALL carry that read data.
REQ-012 Ports mem_addr_r, mem_addr_w  output  ADDR_WIDTH  SHALL drive the memory read and write addresses.
REQ-013 Port mem_data_in  output  DATA_WIDTH  SHALL drive the memory write data.
REQ-014 Port mem_we  output  1  SHALL drive the memory write enable.
REQ-015 Port mem_data_out  input  DATA_WIDTH  SHALL be the memory's registered read data, valid one cycle after address.

Function
REQ-016 A transfer SHALL occur on any cycle with reqN_valid=1 and reqN_ready=1.
REQ-017 The read port and the write port SHALL be arbitrated independently in the same cycle: one read and one write may both be granted, to the same or different requesters' transactions.
REQ-018 Each port SHALL hold a 1-bit round-robin pointer naming the last-granted requester; on contention, the other requester wins.
REQ-019 A pointer SHALL update only on a grant of its port, and SHALL take the granted index.
REQ-020 With a single requester on a port, it SHALL be granted every cycle, with no bubble.
REQ-021 reqN_ready SHALL be combinational from the current valid/we inputs and pointers; it SHALL NOT depend on mem_data_out.
REQ-022 On a write grant: mem_we=1, mem_addr_w=winner addr, mem_data_in=winner wdata, all in the same cycle.
REQ-023 With no write grant: mem_we=0; mem_addr_w and mem_data_in SHALL be don't-care.
REQ-024 On a read grant, mem_addr_r SHALL be the winner's address.
REQ-025 A 1-bit valid and a 1-bit owner tag SHALL be registered on a read grant.
REQ-026 In the cycle after a read grant, rdOWNER_valid=1 and rdOWNER_data=mem_data_out; the other requester's rd valid SHALL be 0 (read latency exactly 1 cycle).
REQ-027 rdN_data SHALL be don't-care when rdN_valid=0.
REQ-028 The arbiter SHALL sustain one read plus one write per cycle indefinitely.
REQ-029 A read and a write to the same address granted in the same cycle SHALL return the old (pre-write) data.
REQ-030 Requesters SHALL hold valid and payload stable until ready; the arbiter SHALL NOT buffer requests.

Reset
REQ-031 While reset=1: both pointers=1 (requester 0 has first priority), read-valid register=0, owner tag=0.
REQ-032 While reset=1, all reqN_ready=0, rdN_valid=0 and mem_we=0, regardless of inputs.
REQ-033 Reset asserted mid-read SHALL discard the pending response; no rdN_valid after deassertion for pre-reset grants.

Verification
REQ-034 Both requesters read continuously (req0 addr 0x10, req1 addr 0x20, mem[0x10]=0x1111, mem[0x20]=0x2222) -> grants alternate 0,1,0,1; rd0_data=0x1111 and rd1_data=0x2222 appear on alternating cycles, one cycle after each grant.
REQ-035 req0 writes 0xABCD to 0x05 while req1 reads 0x05 in the same cycle (old value 0x0000) -> both ready=1; rd1_data=0x0000; a read of 0x05 the following cycle returns 0xABCD.
REQ-036 Only req1 valid (write) for 4 cycles -> req1_ready=1 in all 4 cycles; mem_we=1 in all 4 cycles; req0_ready=0.
REQ-037 Both requesters write contended, req1 drops valid after its first grant -> req0 is granted every remaining cycle, with no idle cycle.
REQ-038 Reset asserted one cycle after a read grant -> rdN_valid=0 immediately and stays 0; after deassertion, a first contended read goes to requester 0.
